// File: rtl/state_pkg.sv
// rtl/state_pkg.sv - game state encoding shared by the game controllers
package state_pkg;

  typedef enum logic [1:0] {
    START   = 2'd0,
    LEVEL_1 = 2'd1,
    FINISH  = 2'd2
  } g_state;

endpackage

// File: rtl/player_ctl_if.sv
// rtl/player_ctl_if.sv - key/state inputs and position outputs of the player controller
interface player_ctl_if;
  import state_pkg::*;

  logic        frame_tick;
  g_state      game_state;
  logic        move_left;
  logic        move_right;
  logic        jump;
  logic [11:0] xpos_player;
  logic [11:0] ypos_player;
  logic        on_ground;

  // Driver side: keyboard, frame timing and game-state controller
  modport master (
    output frame_tick, game_state, move_left, move_right, jump,
    input  xpos_player, ypos_player, on_ground
  );

  // Player controller side
  modport slave (
    input  frame_tick, game_state, move_left, move_right, jump,
    output xpos_player, ypos_player, on_ground
  );

endinterface

// File: rtl/player_ctl.sv
// rtl/player_ctl.sv - player position controller with jump/gravity state machine
module player_ctl
  import state_pkg::*;
#(
  parameter int X_START   = 100,
  parameter int FLOOR_Y   = 450,
  parameter int PLAYER_W  = 32,
  parameter int PLAYER_H  = 48,
  parameter int X_STEP    = 4,
  parameter int JUMP_V    = 12,
  parameter int GRAVITY   = 1,
  parameter int V_MAX     = 10,
  parameter int GAP_X_MIN = 400,
  parameter int GAP_X_MAX = 479,
  parameter int Y_BOTTOM  = 599
) (
  input logic        clk_40,
  input logic        rst,
  player_ctl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GROUND = 2'd1,
    JUMP   = 2'd2,
    FALL   = 2'd3
  } pstate_t;

  // Rightmost legal left edge keeps the whole sprite on the 800-px screen
  localparam logic [11:0] X_MAX      = 12'(800 - PLAYER_W);
  localparam logic [11:0] X_START_C  = 12'(X_START);
  localparam logic [11:0] FLOOR_C    = 12'(FLOOR_Y);
  localparam logic [11:0] TOP_C      = 12'(PLAYER_H);
  localparam logic [11:0] BOTTOM_C   = 12'(Y_BOTTOM);
  localparam logic [11:0] STEP_C     = 12'(X_STEP);
  localparam logic [11:0] GAP_MIN_C  = 12'(GAP_X_MIN);
  localparam logic [11:0] GAP_MAX_C  = 12'(GAP_X_MAX);
  localparam logic [11:0] W_M1_C     = 12'(PLAYER_W - 1);
  localparam logic [4:0]  JUMP_V_C   = 5'(JUMP_V);
  localparam logic [4:0]  GRAVITY_C  = 5'(GRAVITY);
  localparam logic [4:0]  V_MAX_C    = 5'(V_MAX);

  pstate_t     state_q, state_d;
  logic [11:0] x_q, x_d;
  logic [11:0] y_q, y_d;
  logic [4:0]  vel_q, vel_d;
  logic        jump_pend_q, jump_pend_d;
  logic        jump_prev_q;
  logic        on_ground_q, on_ground_d;

  logic        jump_rise;
  logic        over_gap;
  logic [11:0] x_move;
  logic [4:0]  vel_inc;
  logic [4:0]  vel_fall;
  logic [4:0]  vel_dec;
  logic [11:0] y_fall;
  logic [11:0] vel_ext;

  // Datapath helpers: key edge, gap test on pre-update x, clamped steps
  always_comb begin
    jump_rise = bus.jump & ~jump_prev_q;
    over_gap  = (x_q >= GAP_MIN_C) && ((x_q + W_M1_C) <= GAP_MAX_C);

    x_move = x_q;
    if (bus.move_left && !bus.move_right) begin
      x_move = (x_q >= STEP_C) ? (x_q - STEP_C) : 12'd0;
    end else if (bus.move_right && !bus.move_left) begin
      x_move = (x_q <= (X_MAX - STEP_C)) ? (x_q + STEP_C) : X_MAX;
    end

    vel_ext  = {7'd0, vel_q};
    vel_inc  = vel_q + GRAVITY_C;
    vel_fall = (vel_inc > V_MAX_C) ? V_MAX_C : vel_inc;
    vel_dec  = vel_q - GRAVITY_C;
    y_fall   = y_q + {7'd0, vel_fall};
  end

  // Next-state and next-position logic; motion only on frame_tick
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    vel_d       = vel_q;
    // A tick consumes or discards the pending jump; an edge on that same
    // cycle survives to the following tick.
    jump_pend_d = bus.frame_tick ? jump_rise : (jump_pend_q | jump_rise);

    if (state_q == IDLE) begin
      if (bus.game_state == START) begin
        x_d   = X_START_C;
        y_d   = FLOOR_C;
        vel_d = 5'd0;
      end else if (bus.game_state == LEVEL_1) begin
        state_d = GROUND;
      end
    end else if (bus.game_state != LEVEL_1) begin
      state_d = IDLE;
    end else if (bus.frame_tick) begin
      x_d = x_move;
      case (state_q)
        GROUND: begin
          if (over_gap) begin
            state_d = FALL;
            vel_d   = 5'd0;
          end else if (jump_pend_q) begin
            state_d = JUMP;
            vel_d   = JUMP_V_C;
          end
        end
        JUMP: begin
          // Compare before subtracting so y never wraps past the ceiling
          if (y_q < (TOP_C + vel_ext)) begin
            y_d     = TOP_C;
            vel_d   = 5'd0;
            state_d = FALL;
          end else begin
            y_d   = y_q - vel_ext;
            vel_d = vel_dec;
            if (vel_dec == 5'd0) begin
              state_d = FALL;
            end
          end
        end
        FALL: begin
          if (!over_gap && (y_q <= FLOOR_C) && (y_fall >= FLOOR_C)) begin
            y_d     = FLOOR_C;
            vel_d   = 5'd0;
            state_d = GROUND;
          end else begin
            y_d   = (y_fall > BOTTOM_C) ? BOTTOM_C : y_fall;
            vel_d = vel_fall;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    on_ground_d = (state_d == GROUND);
  end

  // State, position and key history registers
  always_ff @(posedge clk_40) begin
    if (rst) begin
      state_q     <= IDLE;
      x_q         <= X_START_C;
      y_q         <= FLOOR_C;
      vel_q       <= 5'd0;
      jump_pend_q <= 1'b0;
      jump_prev_q <= 1'b0;
      on_ground_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      vel_q       <= vel_d;
      jump_pend_q <= jump_pend_d;
      jump_prev_q <= bus.jump;
      on_ground_q <= on_ground_d;
    end
  end

  assign bus.xpos_player = x_q;
  assign bus.ypos_player = y_q;
  assign bus.on_ground   = on_ground_q;

endmodule

// File: tb/tb_player_ctl.sv
// tb/tb_player_ctl.sv - self-checking bench for player_ctl against a behavioural model
module tb_player_ctl;
  import state_pkg::*;

  localparam int M_IDLE   = 0;
  localparam int M_GROUND = 1;
  localparam int M_JUMP   = 2;
  localparam int M_FALL   = 3;

  logic clk_40 = 1'b0;
  logic rst;
  player_ctl_if bus ();

  player_ctl dut (
    .clk_40 (clk_40),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 clk_40 = ~clk_40;

  int checks = 0;
  int errors = 0;

  int m_x, m_y, m_v, m_st;
  bit m_pend, m_prev;
  g_state cur_gs;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // Reference behaviour, one clock edge at a time, in plain integers
  task automatic model(input bit r, input bit t, input g_state g,
                       input bit l, input bit rr, input bit j);
    int  xn, vn, yn;
    bit  rise, gap;
    if (r) begin
      m_x = 100; m_y = 450; m_v = 0; m_st = M_IDLE; m_pend = 0; m_prev = 0;
    end else begin
      rise = j && !m_prev;
      gap  = (m_x >= 400) && (m_x + 31 <= 479);
      if (m_st == M_IDLE) begin
        if (g == START) begin
          m_x = 100; m_y = 450; m_v = 0;
        end else if (g == LEVEL_1) begin
          m_st = M_GROUND;
        end
      end else if (g != LEVEL_1) begin
        m_st = M_IDLE;
      end else if (t) begin
        xn = m_x;
        if (l && !rr) xn = (m_x - 4 < 0) ? 0 : m_x - 4;
        else if (rr && !l) xn = (m_x + 4 > 768) ? 768 : m_x + 4;
        if (m_st == M_GROUND) begin
          if (gap) begin
            m_st = M_FALL; m_v = 0;
          end else if (m_pend) begin
            m_st = M_JUMP; m_v = 12;
          end
        end else if (m_st == M_JUMP) begin
          if (m_y - m_v < 48) begin
            m_y = 48; m_v = 0; m_st = M_FALL;
          end else begin
            m_y = m_y - m_v;
            m_v = m_v - 1;
            if (m_v == 0) m_st = M_FALL;
          end
        end else begin
          vn = (m_v + 1 > 10) ? 10 : m_v + 1;
          yn = m_y + vn;
          if (!gap && m_y <= 450 && yn >= 450) begin
            m_y = 450; m_v = 0; m_st = M_GROUND;
          end else begin
            m_y = (yn > 599) ? 599 : yn;
            m_v = vn;
          end
        end
        m_x = xn;
      end
      m_pend = t ? rise : (m_pend || rise);
      m_prev = j;
    end
  endtask

  task automatic step(input bit r, input bit t, input g_state g,
                      input bit l, input bit rr, input bit j);
    rst            = r;
    bus.frame_tick = t;
    bus.game_state = g;
    bus.move_left  = l;
    bus.move_right = rr;
    bus.jump       = j;
    @(posedge clk_40);
    model(r, t, g, l, rr, j);
    #1;
    chk("xpos", 32'(bus.xpos_player), 32'(m_x));
    chk("ypos", 32'(bus.ypos_player), 32'(m_y));
    chk("on_ground", 32'(bus.on_ground), 32'(m_st == M_GROUND));
  endtask

  // One frame tick followed by a quiet cycle that must leave outputs alone
  task automatic tk(input bit l, input bit rr, input bit j);
    step(1'b0, 1'b1, cur_gs, l, rr, j);
    step(1'b0, 1'b0, cur_gs, l, rr, j);
  endtask

  int exp_y[12] = '{438, 427, 417, 408, 400, 393, 387, 382, 378, 375, 373, 372};
  int exp_d[11] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 10};
  int prev_y;

  initial begin
    bus.frame_tick = 1'b0;
    bus.game_state = START;
    bus.move_left  = 1'b0;
    bus.move_right = 1'b0;
    bus.jump       = 1'b0;
    rst            = 1'b1;
    m_x = 0; m_y = 0; m_v = 0; m_st = M_IDLE; m_pend = 0; m_prev = 0;

    // Reset under START
    cur_gs = START;
    step(1'b1, 1'b0, START, 0, 0, 0);
    step(1'b1, 1'b0, START, 0, 0, 0);
    chk("rst_x", 32'(bus.xpos_player), 32'd100);
    chk("rst_y", 32'(bus.ypos_player), 32'd450);
    chk("rst_og", 32'(bus.on_ground), 32'd0);
    step(1'b0, 1'b0, START, 0, 0, 0);

    // LEVEL_1 enters GROUND without waiting for a tick
    cur_gs = LEVEL_1;
    step(1'b0, 1'b0, LEVEL_1, 0, 0, 0);
    chk("enter_ground", 32'(bus.on_ground), 32'd1);

    // Horizontal movement and clamps
    for (int i = 0; i < 10; i++) tk(0, 1, 0);
    chk("right10", 32'(bus.xpos_player), 32'd140);
    for (int i = 0; i < 40; i++) tk(1, 0, 0);
    chk("left_clamp", 32'(bus.xpos_player), 32'd0);
    for (int i = 0; i < 3; i++) tk(1, 1, 0);
    chk("both_hold", 32'(bus.xpos_player), 32'd0);

    // Jump arc with the key held through landing
    step(1'b0, 1'b0, LEVEL_1, 0, 0, 1);
    tk(0, 0, 1);
    chk("jump_start_y", 32'(bus.ypos_player), 32'd450);
    for (int i = 0; i < 12; i++) begin
      tk(0, 0, 1);
      chk("arc_y", 32'(bus.ypos_player), 32'(exp_y[i]));
    end
    for (int i = 0; i < 40 && bus.on_ground !== 1'b1; i++) tk(0, 0, 1);
    chk("land_og", 32'(bus.on_ground), 32'd1);
    chk("land_y", 32'(bus.ypos_player), 32'd450);
    for (int i = 0; i < 3; i++) tk(0, 0, 1);
    chk("no_repeat_y", 32'(bus.ypos_player), 32'd450);
    chk("no_repeat_og", 32'(bus.on_ground), 32'd1);
    step(1'b0, 1'b0, LEVEL_1, 0, 0, 0);

    // Walk onto the gap and fall through to the screen bottom
    for (int i = 0; i < 100; i++) tk(0, 1, 0);
    chk("at_gap_x", 32'(bus.xpos_player), 32'd400);
    tk(0, 0, 0);
    chk("gap_fall_og", 32'(bus.on_ground), 32'd0);
    chk("gap_fall_y", 32'(bus.ypos_player), 32'd450);
    for (int i = 0; i < 11; i++) begin
      prev_y = int'(bus.ypos_player);
      tk(0, 0, 0);
      chk("fall_dy", 32'(int'(bus.ypos_player) - prev_y), 32'(exp_d[i]));
    end
    chk("past_finish", 32'(bus.ypos_player > 12'd500), 32'd1);
    for (int i = 0; i < 20; i++) tk(0, 0, 0);
    chk("bottom_clamp", 32'(bus.ypos_player), 32'd599);

    // START from a fall: drop to IDLE, then reload
    cur_gs = START;
    step(1'b0, 1'b0, START, 0, 0, 0);
    step(1'b0, 1'b0, START, 0, 0, 0);
    chk("reload_x", 32'(bus.xpos_player), 32'd100);
    chk("reload_y", 32'(bus.ypos_player), 32'd450);
    cur_gs = LEVEL_1;
    step(1'b0, 1'b0, LEVEL_1, 0, 0, 0);

    // FINISH mid-jump freezes the player
    step(1'b0, 1'b0, LEVEL_1, 0, 0, 1);
    tk(0, 0, 0);
    for (int i = 0; i < 3; i++) tk(0, 0, 0);
    cur_gs = FINISH;
    step(1'b0, 1'b0, FINISH, 0, 0, 0);
    for (int i = 0; i < 3; i++) tk(0, 1, 0);
    chk("freeze_y", 32'(bus.ypos_player), 32'd417);
    chk("freeze_x", 32'(bus.xpos_player), 32'd100);
    cur_gs = START;
    step(1'b0, 1'b0, START, 0, 0, 0);
    chk("finish_reload_y", 32'(bus.ypos_player), 32'd450);

    // Reset coincident with a tick mid-fall
    cur_gs = LEVEL_1;
    step(1'b0, 1'b0, LEVEL_1, 0, 0, 0);
    step(1'b0, 1'b0, LEVEL_1, 0, 0, 1);
    tk(0, 0, 0);
    for (int i = 0; i < 14; i++) tk(0, 1, 0);
    step(1'b1, 1'b1, LEVEL_1, 0, 1, 0);
    chk("rst_tick_x", 32'(bus.xpos_player), 32'd100);
    chk("rst_tick_y", 32'(bus.ypos_player), 32'd450);
    chk("rst_tick_og", 32'(bus.on_ground), 32'd0);

    // Randomized play against the model
    for (int i = 0; i < 3000; i++) begin
      int sel;
      sel = int'($urandom_range(0, 39));
      cur_gs = (sel == 0) ? START : (sel == 1) ? FINISH : LEVEL_1;
      step(($urandom_range(0, 499) == 0), ($urandom_range(0, 3) == 0), cur_gs,
           1'($urandom), 1'($urandom), ($urandom_range(0, 5) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/player_ctl.md
Name: player_ctl

Overview:
- Player position controller for the platform game; runs on clk_40 and updates once per video frame.
- Converts the keyboard move/jump requests into the player's xpos/ypos using a jump/gravity state machine.
- Drives ypos_player into the game-state controller, which moves to FINISH when the player falls through the floor gap.
- Consumes game_state (g_state from state_pkg) to enable, freeze or reload the player.

Parameters:
- X_START, 100, player x (left edge) after reset or in START.
- FLOOR_Y, 450, floor line; ypos_player is the feet (bottom) y-coordinate.
- PLAYER_W, 32, player width in pixels.
- PLAYER_H, 48, player height; minimum ypos is PLAYER_H.
- X_STEP, 4, horizontal pixels per frame tick.
- JUMP_V, 12, initial upward velocity, px/tick.
- GRAVITY, 1, velocity change per tick.
- V_MAX, 10, maximum downward velocity.
- GAP_X_MIN, 400, first x of floor gap.
- GAP_X_MAX, 479, last x of floor gap.
- Y_BOTTOM, 599, lowest ypos (screen bottom).

Ports:
- clk_40, in, 1, 40 MHz clock.
- rst, in, 1, reset.
- frame_tick, in, 1, one-cycle pulse per frame; all motion updates occur only on this cycle.
- game_state, in, g_state, current game state.
- move_left, in, 1, level: move left.
- move_right, in, 1, level: move right.
- jump, in, 1, level: jump key.
- xpos_player, out, 12, player left-edge x.
- ypos_player, out, 12, player feet y.
- on_ground, out, 1, high in GROUND state.

Behaviour:
- Reset and clocking:
  - Reset rst, synchronous, active-high; clock clk_40.
  - On reset: xpos_player=X_START, ypos_player=FLOOR_Y, vel=0, jump_pend=0, state IDLE, on_ground=0.
  - All outputs are registered.
- States: IDLE, GROUND, JUMP, FALL. Internal unsigned vel, 5 bits.
- IDLE:
  - If game_state==START: reload X_START/FLOOR_Y and vel=0 every cycle.
  - If game_state==FINISH: hold position.
  - If game_state==LEVEL_1: go to GROUND on the next clk (not tick-gated).
- Any non-IDLE state with game_state!=LEVEL_1: go to IDLE on the next clk (aborts mid-jump). The START reload then applies from IDLE.
- Jump latch:
  - Rising edge of jump (registered previous value) sets jump_pend.
  - On every frame_tick, jump_pend is cleared (consumed or discarded).
  - A rising edge on the tick cycle itself is seen at the next tick.
  - Holding jump never auto-repeats.
- Horizontal movement, on tick in GROUND/JUMP/FALL:
  - left only: x = max(x-X_STEP, 0).
  - right only: x = min(x+X_STEP, 800-PLAYER_W).
  - both or neither: hold.
- over_gap = (x>=GAP_X_MIN) && (x+PLAYER_W-1<=GAP_X_MAX). It is evaluated on the current (pre-update) x.
- GROUND, on tick:
  - If over_gap: go to FALL with vel=0.
  - Else if jump_pend: go to JUMP with vel=JUMP_V.
  - Else stay.
  - y remains FLOOR_Y.
- JUMP, on tick:
  - If y-vel < PLAYER_H: y=PLAYER_H, vel=0, go to FALL.
  - Else y=y-vel, vel=vel-GRAVITY; when the new vel==0, go to FALL.
- FALL, on tick:
  - vn = min(vel+GRAVITY, V_MAX); yn = y+vn.
  - If !over_gap and y<=FLOOR_Y and yn>=FLOOR_Y: y=FLOOR_Y, vel=0, go to GROUND.
  - Else y=min(yn, Y_BOTTOM), vel=vn.
  - Once y>FLOOR_Y, no landing is possible; the player keeps falling and clamps at Y_BOTTOM.
- Latency: position changes are visible the cycle after frame_tick. Without a tick, outputs are stable.
- Arithmetic: 12-bit unsigned, compared before subtracting (no wrap).

Test Plan:
- Reset with game_state=START -> xpos=100, ypos=450, state IDLE. Set LEVEL_1 -> GROUND and on_ground=1 after 1 clk.
- In GROUND, move_right held for 10 ticks -> xpos=140. move_left from x=2 -> xpos=0. Both keys held -> x unchanged.
- Jump pulse then 1 tick -> JUMP, vel=12. Next ticks y=438,427,417,... Apex after 12 ticks at y=372, then FALL and land at exactly 450 with on_ground=1. Jump held through landing -> no second jump.
- Walk to x=400 -> next tick FALL. ypos increments 1,2,3,...,10,10 per tick and passes 500 (FINISH condition). Clamps at 599.
- Mid-jump, game_state=FINISH -> IDLE next clk, position frozen. Then START -> reload 100/450.
- rst asserted mid-FALL coincident with frame_tick -> reset values next cycle; tick ignored.
